serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial subtractor computing diff = a - b - bin over WIDTH bits, one bit per clock, LSB first.
- Built around a single full-subtractor cell and a registered borrow. It is the subtract-side counterpart of the team's adder blocks.
- Driven by a start/done handshake. Used where area matters more than latency, e.g. small datapaths and counters' compare/decrement paths.

Parameters:
- WIDTH, 8, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  request; sampled on clk rising edge
- a  input  WIDTH  minuend; captured when start is accepted
- b  input  WIDTH  subtrahend; captured when start is accepted
- bin  input  1  borrow-in; captured when start is accepted
- busy  output  1  high while a subtraction is in progress
- done  output  1  single-cycle pulse; diff/bout valid
- diff  output  WIDTH  result a - b - bin, modulo 2^WIDTH
- bout  output  1  final borrow-out; 1 when a < b + bin, as unsigned values

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (clk, rst).
- Values while rst is high: state=IDLE, busy=0, done=0, diff=0, bout=0. All internal shift registers, the borrow register and the bit counter are 0.
- States: IDLE, SHIFT, DONE.
- IDLE: start=1 at an edge loads sa<=a, sb<=b, br<=bin and cnt<=0, then moves to SHIFT. start=0 stays in IDLE.
- SHIFT, at each edge:
  - Bit cell: d = sa[0]^sb[0]^br, and br <= (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - d shifts into the MSB of the working result register sd; sa and sb shift right by one.
  - cnt increments. On the edge that processes bit WIDTH-1, go to DONE.
- DONE (exactly one cycle):
  - done=1. diff holds the complete result and bout the final borrow. Both are copied from sd/br on the edge that enters DONE.
  - At the next edge, start=1 is accepted as in IDLE (loads and goes to SHIFT; back-to-back operation). Otherwise go to IDLE.
- Latency: start accepted at edge E0; bits processed at edges E1..E_WIDTH; done=1 in the cycle after E_WIDTH. Back-to-back throughput is one result per WIDTH+1 cycles.
- busy=1 in SHIFT, 0 in IDLE and DONE. busy and done are registered outputs.
- start while in SHIFT is ignored. Operands are not re-captured and no error is flagged.
- diff and bout hold their last value until the next completion. They do not change during SHIFT; only the internal sd changes.
- a, b and bin may change freely after the capture edge.
- Reset asserted mid-operation aborts immediately. No done pulse is generated, all outputs go to 0, and a new start is needed after rst deasserts.
- Arithmetic: unsigned modulo 2^WIDTH. bout is the borrow of the MSB stage and equals the carry-out complement of a + ~b + ~bin.

Test Plan (WIDTH=8 unless noted):
- Basic: a=0x5A, b=0x3C, bin=0, start pulse -> done exactly 8 cycles after the start-capture edge; diff=0x1E, bout=0; busy high for 8 cycles.
- Underflow/borrow: a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1. Then a=0x80, b=0x80, bin=1 -> diff=0xFF, bout=1. Then a=0xFF, b=0x00, bin=1 -> diff=0xFE, bout=0.
- Handshake:
  - start re-asserted in the 3rd SHIFT cycle with different a/b is ignored; the result matches the first operands.
  - start held high during the DONE cycle launches the next op with no IDLE cycle; two done pulses are 9 cycles apart.
  - diff stays stable throughout the second SHIFT phase.
- Reset mid-op: assert rst 4 cycles into SHIFT -> busy, done, diff and bout go 0 immediately (asynchronous). No done pulse appears. After release, a=0x10, b=0x01 gives diff=0x0F, bout=0.
- Randomised/exhaustive, WIDTH=4: all 512 (a, b, bin) combinations -> {bout, diff} equals (a - b - bin) mod 32 reinterpreted as a 5-bit borrow/difference. Repeat with 1000 random vectors at WIDTH=8 and WIDTH=16.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow, sequenced by a start/done FSM.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sa_q, sb_q, sd_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, done_q, bout_q;
    logic [WIDTH-1:0] diff_q;

    logic             d_bit;
    logic             br_d;
    logic [WIDTH-1:0] sd_d;
    logic             last_bit;

    assign d_bit    = sa_q[0] ^ sb_q[0] ^ br_q;
    assign br_d     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
    assign sd_d     = {d_bit, sd_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sd_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= bin;
                        sd_q    <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    sa_q  <= sa_q >> 1;
                    sb_q  <= sb_q >> 1;
                    sd_q  <= sd_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    // The visible result is taken from the next-state values so it includes the MSB.
                    if (last_bit) begin
                        diff_q  <= sd_d;
                        bout_q  <= br_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 4, 8 and 16 against an arithmetic model.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        start4 = 0, start8 = 0, start16 = 0;
    logic [3:0]  a4 = 0, b4 = 0;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] a16 = 0, b16 = 0;
    logic        bin4 = 0, bin8 = 0, bin16 = 0;
    logic        busy4, busy8, busy16, done4, done8, done16, bout4, bout8, bout16;
    logic [3:0]  diff4;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4));
    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_subtractor #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .bin(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer subtraction, borrow is bit w of the (w+1)-bit wrapped result.
    function automatic logic [31:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                          input logic bi);
        logic [31:0] r;
        r = {16'd0, av} - {16'd0, bv} - {31'd0, bi};
        return r & ((32'd1 << (w + 1)) - 32'd1);
    endfunction

    task automatic set_in(input int w, input logic [15:0] av, input logic [15:0] bv,
                          input logic bi, input logic st);
        case (w)
            4:       begin a4 = av[3:0]; b4 = bv[3:0]; bin4 = bi; start4 = st; end
            8:       begin a8 = av[7:0]; b8 = bv[7:0]; bin8 = bi; start8 = st; end
            default: begin a16 = av; b16 = bv; bin16 = bi; start16 = st; end
        endcase
    endtask

    task automatic set_start(input int w, input logic st);
        case (w)
            4:       start4 = st;
            8:       start8 = st;
            default: start16 = st;
        endcase
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4:       return done4;
            8:       return done8;
            default: return done16;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return busy4;
            8:       return busy8;
            default: return busy16;
        endcase
    endfunction

    function automatic logic [31:0] get_res(input int w);
        case (w)
            4:       return {27'd0, bout4, diff4};
            8:       return {23'd0, bout8, diff8};
            default: return {15'd0, bout16, diff16};
        endcase
    endfunction

    // Launches one op and returns at the sample where done is seen (DUT in DONE).
    task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv, input logic bi,
                          output logic [31:0] res, output int lat, output int bcnt);
        set_in(w, av, bv, bi, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        lat  = 0;
        bcnt = 0;
        while (!get_done(w) && lat < 60) begin
            if (get_busy(w)) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
        res = get_res(w);
    endtask

    logic [31:0] res, res1;
    int          lat, bcnt, gap, unstable, pulses;
    logic [15:0] ra, rb;
    logic        rbi;

    initial begin
        // Reset state
        #1 rst = 1'b1;
        #2;
        chk("rst_busy", {31'd0, busy8}, 0);
        chk("rst_done", {31'd0, done8}, 0);
        chk("rst_diff", {24'd0, diff8}, 0);
        chk("rst_bout", {31'd0, bout8}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic
        run_op(8, 16'h5A, 16'h3C, 1'b0, res, lat, bcnt);
        chk("basic_res", res, 32'h01E);
        chk("basic_lat", lat, 8);
        chk("basic_busy_cycles", bcnt, 8);
        chk("basic_busy_in_done", {31'd0, busy8}, 0);
        @(posedge clk); #1;
        chk("basic_done_pulse", {31'd0, done8}, 0);
        chk("basic_diff_hold", {23'd0, bout8, diff8}, 32'h01E);

        // Borrow cases
        run_op(8, 16'h00, 16'h01, 1'b0, res, lat, bcnt);
        chk("uflow_0m1", res, 32'h1FF);
        run_op(8, 16'h80, 16'h80, 1'b1, res, lat, bcnt);
        chk("uflow_80m80m1", res, 32'h1FF);
        run_op(8, 16'hFF, 16'h00, 1'b1, res, lat, bcnt);
        chk("ff_m0_m1", res, 32'h0FE);
        @(posedge clk); #1;

        // start during the 3rd SHIFT cycle is ignored
        set_in(8, 16'h9C, 16'h27, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_start(8, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        set_in(8, 16'h11, 16'hEE, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_start(8, 1'b0);
        lat = 3;
        while (!done8 && lat < 60) begin @(posedge clk); #1; lat++; end
        chk("ignore_lat", lat, 8);
        chk("ignore_res", {23'd0, bout8, diff8}, 32'h075);
        @(posedge clk); #1;
        chk("ignore_no_restart", {31'd0, busy8}, 0);

        // Back-to-back: start held through DONE
        run_op(8, 16'h37, 16'h59, 1'b0, res1, lat, bcnt);
        chk("b2b_res1", res1, 32'h1DE);
        set_in(8, 16'hA5, 16'h0F, 1'b1, 1'b1);
        @(posedge clk); #1;
        set_start(8, 1'b0);
        gap = 1;
        unstable = 0;
        while (!done8 && gap < 60) begin
            if ({23'd0, bout8, diff8} != res1) unstable++;
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b_gap", gap, 9);
        chk("b2b_res2", {23'd0, bout8, diff8}, 32'h095);
        chk("b2b_diff_stable", unstable, 0);
        @(posedge clk); #1;

        // Reset mid-operation
        set_in(8, 16'hF3, 16'h21, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_start(8, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        chk("midrst_busy_before", {31'd0, busy8}, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, busy8}, 0);
        chk("midrst_done", {31'd0, done8}, 0);
        chk("midrst_diff", {24'd0, diff8}, 0);
        chk("midrst_bout", {31'd0, bout8}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done8 || busy8) pulses++;
        end
        chk("midrst_no_done", pulses, 0);
        run_op(8, 16'h10, 16'h01, 1'b0, res, lat, bcnt);
        chk("midrst_after", res, 32'h00F);
        @(posedge clk); #1;

        // Exhaustive WIDTH=4
        for (int i = 0; i < 512; i++) begin
            ra  = 16'(i[3:0]);
            rb  = 16'(i[7:4]);
            rbi = i[8];
            run_op(4, ra, rb, rbi, res, lat, bcnt);
            chk("w4_res", res, model(4, ra, rb, rbi));
            chk("w4_lat", lat, 4);
        end

        // Random WIDTH=8 and WIDTH=16
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom_range(0, 255));
            rb  = 16'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            run_op(8, ra, rb, rbi, res, lat, bcnt);
            chk("w8_res", res, model(8, ra, rb, rbi));
        end
        for (int i = 0; i < 1000; i++) begin
            ra  = 16'($urandom_range(0, 65535));
            rb  = 16'($urandom_range(0, 65535));
            rbi = 1'($urandom_range(0, 1));
            run_op(16, ra, rb, rbi, res, lat, bcnt);
            chk("w16_res", res, model(16, ra, rb, rbi));
            chk("w16_lat", lat, 16);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
